dds_bus_ctrl: RTL and testbench

Sequencer for the DDS chip's 6-bit-address / 8-bit-data parallel programming port. It runs the power-on master-reset sequence, then accepts register-write requests through a valid/ready handshake into a small FIFO. It replays each request onto the chip bus with correct setup/strobe/hold timing and pulses io_ud to commit a batch. It sits between the frequency/phase tuning logic and the DDS pins.

---
 rtl/dds_bus_ctrl.sv | 239 +++++++++++++++++++++++
 tb/tb_dds_bus_ctrl.sv | 492 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dds_bus_ctrl.sv
// dds_bus_ctrl: programming-port sequencer for a DDS chip with a 6-bit address / 8-bit data
// parallel bus. Runs the power-on master-reset sequence, buffers register writes in a small
// FIFO and replays each one with setup/strobe/hold timing, pulsing io_ud after a write that
// closes a batch.
// Build option: define DDS_INIT_SEQ_EN to include the mst_rst power-on sequence
// (INIT_RST/INIT_GAP). Without it mst_rst is tied low and the sequencer starts in IDLE.
module dds_bus_ctrl #(
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned RST_CYCLES = 16,
    parameter int unsigned UD_CYCLES  = 4,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [5:0] req_addr,
    input  logic [7:0] req_data,
    input  logic       req_last,
    output logic       busy,
    output logic       mst_rst,
    output logic [5:0] a,
    output logic [7:0] d,
    output logic       wrb,
    output logic       io_ud
);

    localparam int unsigned MaxAB  = (CLK_DIV > RST_CYCLES) ? CLK_DIV : RST_CYCLES;
    localparam int unsigned MaxCyc = (MaxAB > UD_CYCLES) ? MaxAB : UD_CYCLES;
    localparam int unsigned PhW    = $clog2(MaxCyc) + 1;
    localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW   = PtrW + 1;
    localparam int unsigned EntW   = 15;

    localparam logic [PhW-1:0]  DivLoad = PhW'(CLK_DIV - 1);
    localparam logic [PhW-1:0]  UdLoad  = PhW'(UD_CYCLES - 1);
    localparam logic [CntW-1:0] CntFull = CntW'(FIFO_DEPTH);

`ifdef DDS_INIT_SEQ_EN
    typedef enum logic [2:0] {
        StInitRst, StInitGap, StIdle, StSetup, StStrobe, StHold, StUpdate
    } state_e;
    localparam logic [PhW-1:0] RstLoad  = PhW'(RST_CYCLES - 1);
    localparam state_e         StReset  = StInitRst;
    localparam logic [PhW-1:0] CntReset = RstLoad;
`else
    typedef enum logic [2:0] {
        StIdle, StSetup, StStrobe, StHold, StUpdate
    } state_e;
    localparam state_e         StReset  = StIdle;
    localparam logic [PhW-1:0] CntReset = '0;
`endif

    state_e          state_q;
    logic [PhW-1:0]  cnt_q;
    logic            wrb_q;
    logic            io_ud_q;
    logic [5:0]      a_q;
    logic [7:0]      d_q;
    logic            last_q;
    logic            req_ready_q;
    logic            busy_q;

    logic [EntW-1:0] mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic [CntW-1:0] count_d;

    logic            push;
    logic            pop;
    logic            phase_done;
    logic            init_next;
    logic            idle_next;
    logic [EntW-1:0] head;

    // Handshake, FIFO occupancy and a peek at where the FSM goes next (for registered flags)
    always_comb begin
        push       = req_valid && req_ready_q;
        pop        = (state_q == StIdle) && (count_q != '0);
        head       = mem_q[rd_ptr_q];
        phase_done = (cnt_q == '0);

        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CntW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CntW'(1);
        end

        init_next = 1'b0;
        idle_next = 1'b0;
        case (state_q)
`ifdef DDS_INIT_SEQ_EN
            StInitRst: init_next = 1'b1;
            StInitGap: begin
                init_next = !phase_done;
                idle_next = phase_done;
            end
`endif
            StIdle:   idle_next = !pop;
            StHold:   idle_next = phase_done && !last_q;
            StUpdate: idle_next = phase_done;
            default:  idle_next = 1'b0;
        endcase
    end

    // Request storage; contents need no reset, validity is tracked by the pointers
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {req_last, req_addr, req_data};
        end
    end

    // FIFO pointers plus registered ready/busy derived from next-cycle occupancy and state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            count_q     <= count_d;
            req_ready_q <= !init_next && (count_d != CntFull);
            busy_q      <= !idle_next || (count_d != '0);
        end
    end

`ifdef DDS_INIT_SEQ_EN
    logic mst_rst_q;
    assign mst_rst = mst_rst_q;
`else
    assign mst_rst = 1'b0;
`endif

    // Sequencer FSM; every bus pin is driven from a register updated here
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StReset;
            cnt_q     <= CntReset;
            wrb_q     <= 1'b1;
            io_ud_q   <= 1'b0;
            a_q       <= '0;
            d_q       <= '0;
            last_q    <= 1'b0;
`ifdef DDS_INIT_SEQ_EN
            mst_rst_q <= 1'b1;
`endif
        end else begin
            case (state_q)
`ifdef DDS_INIT_SEQ_EN
                StInitRst: begin
                    if (phase_done) begin
                        state_q   <= StInitGap;
                        cnt_q     <= RstLoad;
                        mst_rst_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - PhW'(1);
                    end
                end
                StInitGap: begin
                    if (phase_done) begin
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_q - PhW'(1);
                    end
                end
`endif
                StIdle: begin
                    // a/d only ever change here, so the bus keeps the last write when idle
                    if (pop) begin
                        {last_q, a_q, d_q} <= head;
                        cnt_q              <= DivLoad;
                        state_q            <= StSetup;
                    end
                end
                StSetup: begin
                    if (phase_done) begin
                        state_q <= StStrobe;
                        wrb_q   <= 1'b0;
                        cnt_q   <= DivLoad;
                    end else begin
                        cnt_q <= cnt_q - PhW'(1);
                    end
                end
                StStrobe: begin
                    if (phase_done) begin
                        state_q <= StHold;
                        wrb_q   <= 1'b1;
                        cnt_q   <= DivLoad;
                    end else begin
                        cnt_q <= cnt_q - PhW'(1);
                    end
                end
                StHold: begin
                    if (phase_done) begin
                        if (last_q) begin
                            state_q <= StUpdate;
                            io_ud_q <= 1'b1;
                            cnt_q   <= UdLoad;
                        end else begin
                            state_q <= StIdle;
                        end
                    end else begin
                        cnt_q <= cnt_q - PhW'(1);
                    end
                end
                StUpdate: begin
                    if (phase_done) begin
                        state_q <= StIdle;
                        io_ud_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - PhW'(1);
                    end
                end
                default: begin
                    state_q <= StIdle;
                    wrb_q   <= 1'b1;
                    io_ud_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign busy      = busy_q;
    assign a         = a_q;
    assign d         = d_q;
    assign wrb       = wrb_q;
    assign io_ud     = io_ud_q;

endmodule

// File: tb/tb_dds_bus_ctrl.sv
// Testbench for dds_bus_ctrl: scoreboard of accepted requests compared against the writes seen
// on the DDS bus, plus cycle-exact checks of init, strobe/update timing, FIFO full and reset.
module tb_dds_bus_ctrl;

    localparam int unsigned CLK_DIV     = 4;
    localparam int unsigned RST_CYCLES  = 16;
    localparam int unsigned UD_CYCLES   = 4;
    localparam int unsigned FIFO_DEPTH  = 8;
    localparam int unsigned WritePeriod = 3 * CLK_DIV + 1;
`ifdef DDS_INIT_SEQ_EN
    localparam logic ExpMstRst = 1'b1;
`else
    localparam logic ExpMstRst = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic [5:0] req_addr = '0;
    logic [7:0] req_data = '0;
    logic       req_last = 1'b0;
    logic       req_ready;
    logic       busy;
    logic       mst_rst;
    logic [5:0] a;
    logic [7:0] d;
    logic       wrb;
    logic       io_ud;

    dds_bus_ctrl #(
        .CLK_DIV   (CLK_DIV),
        .RST_CYCLES(RST_CYCLES),
        .UD_CYCLES (UD_CYCLES),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_addr (req_addr),
        .req_data (req_data),
        .req_last (req_last),
        .busy     (busy),
        .mst_rst  (mst_rst),
        .a        (a),
        .d        (d),
        .wrb      (wrb),
        .io_ud    (io_ud)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [31:0] c;
        logic [5:0]  a;
        logic [7:0]  d;
    } wr_t;

    wr_t         obs_q[$];
    int unsigned ud_q[$];
    logic [14:0] exp_q[$];
    logic        prev_wrb = 1'b1;
    logic        prev_ud = 1'b0;
    logic [5:0]  prev_a = '0;
    logic [7:0]  prev_d = '0;
    int          ad_moves = 0;

    // Bus monitor: records each strobe and update pulse with its cycle stamp
    always @(negedge clk) begin
        if (prev_wrb === 1'b1 && wrb === 1'b0) obs_q.push_back({cyc, a, d});
        if (prev_ud === 1'b0 && io_ud === 1'b1) ud_q.push_back(cyc);
        if (wrb === 1'b0 && (a !== prev_a || d !== prev_d)) ad_moves++;
        prev_wrb = wrb;
        prev_ud  = io_ud;
        prev_a   = a;
        prev_d   = d;
    end

    task automatic push_one(input logic [5:0] ad, input logic [7:0] dt, input logic lst);
        bit acc = 1'b0;
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = ad;
        req_data  = dt;
        req_last  = lst;
        for (int n = 0; n < 400 && !acc; n++) begin
            acc = req_ready;
            @(posedge clk);
            if (!acc) @(negedge clk);
        end
        if (acc) begin
            exp_q.push_back({lst, ad, dt});
        end else begin
            checks++;
            errors++;
            $display("FAIL push_timeout addr=%h req_ready=%b expected 1", ad, req_ready);
        end
    endtask

    task automatic release_valid();
        @(negedge clk);
        req_valid = 1'b0;
        req_last  = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        @(negedge clk);
        while ((busy !== 1'b0 || req_ready !== 1'b1) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 2000) begin
            errors++;
            $display("FAIL %s idle_timeout busy=%b ready=%b expected 0/1", tag, busy, req_ready);
        end
    endtask

    task automatic check_init_seq(input string tag);
        int n = 0;
        int bad = 0;
        while (mst_rst === 1'b1 && n < 100) begin
            n++;
            if (wrb !== 1'b1 || io_ud !== 1'b0 || req_ready !== 1'b0) bad++;
            @(negedge clk);
        end
        checks++;
        if (n != RST_CYCLES) begin
            errors++;
            $display("FAIL %s mst_rst_high cycles=%0d expected %0d", tag, n, RST_CYCLES);
        end
        n = 0;
        while (req_ready !== 1'b1 && n < 100) begin
            n++;
            if (mst_rst !== 1'b0 || wrb !== 1'b1 || io_ud !== 1'b0) bad++;
            @(negedge clk);
        end
        checks++;
        if (n != RST_CYCLES) begin
            errors++;
            $display("FAIL %s ready_gap cycles=%0d expected %0d", tag, n, RST_CYCLES);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s init_pins bad_samples=%0d expected 0", tag, bad);
        end
    endtask

    task automatic test_reset();
        int bad = 0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (mst_rst !== ExpMstRst) begin
            errors++;
            $display("FAIL reset_mst_rst got=%b expected %b", mst_rst, ExpMstRst);
        end
        checks++;
        if ({wrb, io_ud} !== 2'b10) begin
            errors++;
            $display("FAIL reset_wrb_ud got=%b%b expected 10", wrb, io_ud);
        end
        checks++;
        if ({a, d} !== 14'h0) begin
            errors++;
            $display("FAIL reset_bus got a=%h d=%h expected 00/00", a, d);
        end
        checks++;
        if ({req_ready, busy} !== 2'b01) begin
            errors++;
            $display("FAIL reset_ready_busy got=%b%b expected 01", req_ready, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
`ifdef DDS_INIT_SEQ_EN
        check_init_seq("reset");
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy_after_init got=%b expected 0", busy);
        end
`else
        @(posedge clk);
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL noinit_ready got=%b expected 1", req_ready);
        end
        req_valid = 1'b1;
        req_addr  = 6'h15;
        req_data  = 8'hA7;
        req_last  = 1'b0;
        @(posedge clk);
        exp_q.push_back({1'b0, 6'h15, 8'hA7});
        #1;
        req_valid = 1'b0;
        checks++;
        if ({a, d} !== 14'h0) begin
            errors++;
            $display("FAIL noinit_bus_early got a=%h d=%h expected 00/00", a, d);
        end
        @(posedge clk);
        #1;
        begin
            logic [14:0] e;
            e = exp_q.pop_front();
            checks++;
            if ({a, d} !== e[13:0]) begin
                errors++;
                $display("FAIL noinit_bus got a=%h d=%h expected %h/%h", a, d, e[13:8], e[7:0]);
            end
        end
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (mst_rst !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL noinit_mst_rst high_samples=%0d expected 0", bad);
        end
`endif
        wait_idle("reset");
    endtask

    task automatic test_single_write();
        logic [14:0] e;
        logic [1:0]  exp_pins;
        wait_idle("single");
        obs_q.delete();
        ud_q.delete();
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = 6'h04;
        req_data  = 8'h0C;
        req_last  = 1'b1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL single_ready got=%b expected 1", req_ready);
        end
        @(posedge clk);
        exp_q.push_back({1'b1, 6'h04, 8'h0C});
        @(negedge clk);
        req_valid = 1'b0;
        req_last  = 1'b0;
        checks++;
        if ({a, d} === {6'h04, 8'h0C}) begin
            errors++;
            $display("FAIL single_bus_early got a=%h d=%h expected previous value", a, d);
        end
        e = exp_q.pop_front();
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            exp_pins = {!(k >= 4 && k < 8), (k >= 12 && k < 16)};
            checks++;
            if ({wrb, io_ud} !== exp_pins) begin
                errors++;
                $display("FAIL single_pins k=%0d got wrb/io_ud=%b%b expected %b", k, wrb, io_ud,
                         exp_pins);
            end
            checks++;
            if ({a, d} !== e[13:0]) begin
                errors++;
                $display("FAIL single_bus k=%0d got a=%h d=%h expected %h/%h", k, a, d,
                         e[13:8], e[7:0]);
            end
        end
    endtask

    task automatic test_ten_writes();
        int n = 0;
        logic [14:0] e;
        wait_idle("ten");
        obs_q.delete();
        ud_q.delete();
        exp_q.delete();
        for (int i = 0; i < 10; i++) begin
            push_one((i < 6) ? 6'(4 + i) : 6'(29 + i - 6), 8'(8'hA0 + i), (i == 9));
        end
        release_valid();
        while ((obs_q.size() < 10 || busy !== 1'b0) && n < 600) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (obs_q.size() != 10) begin
            errors++;
            $display("FAIL ten_count writes=%0d expected 10", obs_q.size());
        end else begin
            for (int i = 0; i < 10; i++) begin
                e = exp_q.pop_front();
                checks++;
                if ({obs_q[i].a, obs_q[i].d} !== e[13:0]) begin
                    errors++;
                    $display("FAIL ten_data idx=%0d got %h/%h expected %h/%h", i, obs_q[i].a,
                             obs_q[i].d, e[13:8], e[7:0]);
                end
                if (i > 0) begin
                    checks++;
                    if (obs_q[i].c - obs_q[i-1].c != WritePeriod) begin
                        errors++;
                        $display("FAIL ten_spacing idx=%0d got=%0d expected %0d", i,
                                 obs_q[i].c - obs_q[i-1].c, WritePeriod);
                    end
                end
            end
            checks++;
            if (ud_q.size() != 1) begin
                errors++;
                $display("FAIL ten_ud_count got=%0d expected 1", ud_q.size());
            end else begin
                checks++;
                if (ud_q[0] != obs_q[9].c + 2 * CLK_DIV) begin
                    errors++;
                    $display("FAIL ten_ud_time got=%0d expected %0d", ud_q[0],
                             obs_q[9].c + 2 * CLK_DIV);
                end
            end
        end
    endtask

    task automatic test_fifo_full();
        int          accepted = 0;
        int          remaining = 12;
        int          first_drop = -1;
        int          n = 0;
        logic        rdy;
        logic        prev_rdy = 1'b1;
        int unsigned rises[$];
        logic [14:0] e;
        wait_idle("full");
        obs_q.delete();
        ud_q.delete();
        exp_q.delete();
        ad_moves = 0;
        // Primer occupies the bus so the following requests pile up in the FIFO
        push_one(6'h30, 8'hEE, 1'b0);
        while (remaining > 0 && n < 1000) begin
            @(negedge clk);
            req_valid = 1'b1;
            req_addr  = 6'(6'h20 + accepted);
            req_data  = 8'(8'h50 + 3 * accepted);
            req_last  = (remaining == 1);
            rdy = req_ready;
            if (!rdy && first_drop < 0) first_drop = accepted;
            if (rdy && !prev_rdy) rises.push_back(cyc);
            prev_rdy = rdy;
            @(posedge clk);
            if (rdy) begin
                exp_q.push_back({req_last, req_addr, req_data});
                accepted++;
                remaining--;
            end
            n++;
        end
        release_valid();
        checks++;
        if (first_drop != FIFO_DEPTH) begin
            errors++;
            $display("FAIL full_drop accepted_before_drop=%0d expected %0d", first_drop,
                     FIFO_DEPTH);
        end
        n = 0;
        while ((obs_q.size() < 13 || busy !== 1'b0) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (rises.size() != 4) begin
            errors++;
            $display("FAIL full_rises got=%0d expected 4", rises.size());
        end
        foreach (rises[i]) begin
            bit found;
            found = 1'b0;
            foreach (obs_q[j]) if (obs_q[j].c == rises[i] + CLK_DIV) found = 1'b1;
            checks++;
            if (!found) begin
                errors++;
                $display("FAIL full_rise_after_pop rise_cycle=%0d no pop at that edge", rises[i]);
            end
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL full_count writes=%0d expected %0d", obs_q.size(), exp_q.size());
        end else begin
            foreach (obs_q[i]) begin
                e = exp_q.pop_front();
                checks++;
                if ({obs_q[i].a, obs_q[i].d} !== e[13:0]) begin
                    errors++;
                    $display("FAIL full_data idx=%0d got %h/%h expected %h/%h", i, obs_q[i].a,
                             obs_q[i].d, e[13:8], e[7:0]);
                end
            end
        end
        checks++;
        if (ud_q.size() != 1) begin
            errors++;
            $display("FAIL full_ud_count got=%0d expected 1", ud_q.size());
        end
        checks++;
        if (ad_moves != 0) begin
            errors++;
            $display("FAIL full_bus_stable changes_during_strobe=%0d expected 0", ad_moves);
        end
    endtask

    task automatic test_reset_midwrite();
        int n = 0;
        wait_idle("midrst");
        exp_q.delete();
        push_one(6'h11, 8'h21, 1'b0);
        push_one(6'h12, 8'h22, 1'b0);
        push_one(6'h13, 8'h23, 1'b1);
        release_valid();
        while (wrb !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 100) begin
            errors++;
            $display("FAIL midrst_no_strobe wrb=%b expected 0", wrb);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({wrb, io_ud} !== 2'b10) begin
            errors++;
            $display("FAIL midrst_pins got wrb/io_ud=%b%b expected 10", wrb, io_ud);
        end
        checks++;
        if ({mst_rst, req_ready, busy} !== {ExpMstRst, 2'b01}) begin
            errors++;
            $display("FAIL midrst_ctl got=%b%b%b expected %b01", mst_rst, req_ready, busy,
                     ExpMstRst);
        end
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        obs_q.delete();
        ud_q.delete();
`ifdef DDS_INIT_SEQ_EN
        check_init_seq("midrst");
`endif
        wait_idle("midrst");
        repeat (3 * WritePeriod) @(negedge clk);
        checks++;
        if (obs_q.size() != 0 || ud_q.size() != 0) begin
            errors++;
            $display("FAIL midrst_stale writes=%0d updates=%0d expected 0/0", obs_q.size(),
                     ud_q.size());
        end
        checks++;
        if ({busy, req_ready, a, d} !== {2'b01, 14'h0}) begin
            errors++;
            $display("FAIL midrst_flushed got busy=%b ready=%b a=%h d=%h expected 0/1/00/00",
                     busy, req_ready, a, d);
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_ten_writes();
        test_fifo_full();
        test_reset_midwrite();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not complete, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
